sa_tile_ctrl: RTL

- Parametrised, non-square successor to the square ifmap-stationary systolic array (SA).
- Includes its own load/compute/drain FSM, input skew, output deskew and valid/ready handshakes.
- Operation: a stationary ROWS×COLS operand S is loaded, then K stream vectors a[k] (ROWS elements each) pass through the tile. Each stream beat produces one deskewed output vector y[k][c] = Σr a[k][r]·S[r][c].
- Sits between the buffer/DMA front-end and the accumulator bank in the MMU.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_pe.sv | 34 +++
 rtl/sa_tile_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic tile: FSM states, pipeline latency and default widths.
package sa_pkg;

  localparam int SA_DEF_ROWS       = 4;
  localparam int SA_DEF_COLS       = 4;
  localparam int SA_DEF_DATA_WIDTH = 8;
  localparam int SA_DEF_PSUM_WIDTH = 32;
  localparam int SA_DEF_K_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } sa_state_e;

  // Cycles from an accepted stream beat to its aligned output vector.
  function automatic int sa_latency(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Registered MAC cell: stationary operand, stream pass-through to the right, psum pass-through downward.
module sa_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_load,
  input  logic [DATA_WIDTH-1:0] s_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [PSUM_WIDTH-1:0] psum_out
);

  logic [DATA_WIDTH-1:0]   s_reg;
  logic [2*DATA_WIDTH-1:0] prod;

  assign prod = {{DATA_WIDTH{1'b0}}, a_in} * {{DATA_WIDTH{1'b0}}, s_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg    <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (s_load) s_reg <= s_in;
      a_out    <= a_in;
      // Unsigned product, wrapping accumulation.
      psum_out <= psum_in + PSUM_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/sa_tile_ctrl.sv
// Non-square stationary-operand systolic tile with load/run/drain control, skew and deskew.
// Optional stream-bubble counter stall_cnt_o is built when SA_PERF_EN is defined.
module sa_tile_ctrl import sa_pkg::*; #(
  parameter int ROWS       = SA_DEF_ROWS,
  parameter int COLS       = SA_DEF_COLS,
  parameter int DATA_WIDTH = SA_DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = SA_DEF_PSUM_WIDTH,
  parameter int K_W        = SA_DEF_K_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [K_W-1:0]             cfg_k_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [COLS*DATA_WIDTH-1:0] s_data_i,
  input  logic                       a_valid_i,
  output logic                       a_ready_o,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data_i,
  output logic                       y_valid_o,
  output logic [COLS*PSUM_WIDTH-1:0] y_data_o,
  output logic                       busy_o,
  output logic                       done_o
`ifdef SA_PERF_EN
  ,
  output logic [K_W-1:0]             stall_cnt_o
`endif
);

  localparam int L    = sa_latency(ROWS, COLS);
  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DC_W = $clog2(L);
  localparam logic [RC_W-1:0] ROW_LAST   = RC_W'(ROWS - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(L - 1);

  sa_state_e        state_reg;
  logic [K_W-1:0]   k_reg;
  logic [K_W-1:0]   beat_cnt_reg;
  logic [RC_W-1:0]  row_cnt_reg;
  logic [DC_W-1:0]  drain_cnt_reg;
  logic             s_fire;
  logic             a_fire;

  assign s_fire = s_valid_i & s_ready_o;
  assign a_fire = a_valid_i & a_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      k_reg         <= '0;
      beat_cnt_reg  <= '0;
      row_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      s_ready_o     <= 1'b0;
      a_ready_o     <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg   <= ST_LOAD;
            k_reg       <= cfg_k_i;
            row_cnt_reg <= '0;
            s_ready_o   <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (s_fire) begin
            row_cnt_reg <= row_cnt_reg + 1'b1;
            if (row_cnt_reg == ROW_LAST) begin
              s_ready_o     <= 1'b0;
              beat_cnt_reg  <= '0;
              drain_cnt_reg <= '0;
              if (k_reg == '0) begin
                state_reg <= ST_DRAIN;
              end else begin
                state_reg <= ST_RUN;
                a_ready_o <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (a_fire) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (beat_cnt_reg == k_reg - K_W'(1)) begin
              state_reg <= ST_DRAIN;
              a_ready_o <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg + 1'b1;
          // Drain covers the full pipe so the last output has left before done.
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg <= ST_IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef SA_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (state_reg == ST_IDLE && start_i) begin
      stall_cnt_o <= '0;
    end else if (state_reg == ST_RUN && !a_valid_i && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

  logic [DATA_WIDTH-1:0] a_row [ROWS];
  logic [DATA_WIDTH-1:0] s_col [COLS];
  logic [ROWS-1:0]       s_wr;
  logic [DATA_WIDTH-1:0] a_bus [ROWS][COLS+1];
  logic [PSUM_WIDTH-1:0] p_bus [ROWS+1][COLS];
  logic [PSUM_WIDTH-1:0] y_col [COLS];
  logic [L-2:0]          v_pipe_reg;

  // Input skew: row r enters r cycles late; non-accepted cycles inject zeros.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign a_row[gi] = a_fire ? a_data_i[(ROWS-1-gi)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign s_wr[gi]  = s_fire && (row_cnt_reg == RC_W'(gi));
    if (gi == 0) begin : g_direct
      assign a_bus[gi][0] = a_row[gi];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dly_reg [gi];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < gi; i++) dly_reg[i] <= '0;
        end else begin
          dly_reg[0] <= a_row[gi];
          for (int i = 1; i < gi; i++) dly_reg[i] <= dly_reg[i-1];
        end
      end
      assign a_bus[gi][0] = dly_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign s_col[gi]    = s_data_i[(COLS-1-gi)*DATA_WIDTH +: DATA_WIDTH];
    assign p_bus[0][gi] = '0;
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_pe_r
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe_c
      sa_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .PSUM_WIDTH(PSUM_WIDTH)
      ) u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_load   (s_wr[gi]),
        .s_in     (s_col[gj]),
        .a_in     (a_bus[gi][gj]),
        .psum_in  (p_bus[gi][gj]),
        .a_out    (a_bus[gi][gj+1]),
        .psum_out (p_bus[gi+1][gj])
      );
    end
  end

  // Output deskew: column c waits COLS-1-c cycles so all columns align.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_deskew
    if (gi == COLS - 1) begin : g_direct
      assign y_col[gi] = p_bus[ROWS][gi];
    end else begin : g_dly
      logic [PSUM_WIDTH-1:0] dly_reg [COLS-1-gi];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < COLS - 1 - gi; i++) dly_reg[i] <= '0;
        end else begin
          dly_reg[0] <= p_bus[ROWS][gi];
          for (int i = 1; i < COLS - 1 - gi; i++) dly_reg[i] <= dly_reg[i-1];
        end
      end
      assign y_col[gi] = dly_reg[COLS-2-gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe_reg <= '0;
      y_valid_o  <= 1'b0;
      y_data_o   <= '0;
    end else begin
      v_pipe_reg[0] <= a_fire;
      for (int i = 1; i < L - 1; i++) v_pipe_reg[i] <= v_pipe_reg[i-1];
      y_valid_o <= v_pipe_reg[L-2];
      for (int c = 0; c < COLS; c++) y_data_o[(COLS-1-c)*PSUM_WIDTH +: PSUM_WIDTH] <= y_col[c];
    end
  end

endmodule
